dual_fetch_unit: RTL and testbench

Front end of the dual-issue core. Fetches two consecutive 16-bit instructions per cycle from a synchronous instruction memory and buffers them in a small 2-in/2-out queue. It drives the registered IR/PC pair consumed by pipelines p0 (older) and p1 (younger). It advances on the hazard unit's `fetch_next` and flushes on branch redirects from the BGU.

---
 rtl/kl_fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/dual_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_dual_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kl_fetch_pkg.sv
// Shared types for the dual-issue fetch front end.
// Holds widths, the bubble encoding, the queue entry and the FSM state.
package kl_fetch_pkg;

  localparam int PC_W = 8;
  localparam int IR_W = 16;

  localparam logic [IR_W-1:0] NOP_INST = 16'h0000;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// 2-push/2-pop FIFO of fetch entries between memory and issue.
// Ports: push_n (0/2), push0/1, pop_n (0-2), flush, count, head0/1.
module fetch_queue
  import kl_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             push_n,
  input  fetch_entry_t           push0,
  input  fetch_entry_t           push1,
  input  logic [1:0]             pop_n,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head0,
  output fetch_entry_t           head1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q;
  logic [AW-1:0]  wr_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push;
  logic [CW:0]    fill_w;

  assign do_push = (push_n == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(2);
      rd_q  <= rd_q + AW'(pop_n);
      cnt_q <= cnt_q + (do_push ? CW'(2) : CW'(0))
             - CW'(pop_n);
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_q]          <= push0;
      mem_q[wr_q + AW'(1)] <= push1;
    end
  end

  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd_q + AW'(1)];
  assign count = cnt_q;

  assign fill_w = {1'b0, cnt_q} + (CW+1)'(push_n);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    flush || (fill_w <= (CW+1)'(DEPTH) + (CW+1)'(pop_n))
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    flush || (CW'(pop_n) <= cnt_q)
  );

endmodule

// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch: two words per request, queued, issued as p0/p1.
// Ports: clk, rst, fetch_next, redirect_*, im_*, p0_*/p1_* outputs.
module dual_fetch_unit
  import kl_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_next,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr0,
  output logic [PC_W-1:0] im_addr1,
  input  logic [IR_W-1:0] im_rdata0,
  input  logic [IR_W-1:0] im_rdata1,
  output logic [IR_W-1:0] p0_IR_out,
  output logic [IR_W-1:0] p1_IR_out,
  output logic [PC_W-1:0] p0_PC_out,
  output logic [PC_W-1:0] p1_PC_out,
  output logic            p0_valid_out,
  output logic            p1_valid_out
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q;
  fetch_state_e    state_q, state_d;
  logic            inflight_q;
  logic            squash_q;

  logic [IR_W-1:0] p0_ir_q, p1_ir_q;
  logic [PC_W-1:0] p0_pc_q, p1_pc_q;
  logic            p0_v_q, p1_v_q;

  logic [CW-1:0]   q_count;
  fetch_entry_t    q_head0, q_head1;
  fetch_entry_t    q_push0, q_push1;
  logic [1:0]      push_n, pop_n;
  logic            adv;
  logic            room;
  logic [CW:0]     occ_w;

  assign adv = fetch_next | ~p0_v_q;

  always_comb begin
    pop_n = 2'd0;
    if (!redirect_valid && adv) begin
      if (q_count >= CW'(2))      pop_n = 2'd2;
      else if (q_count == CW'(1)) pop_n = 2'd1;
    end
  end

  // Occupancy once this cycle's pop and in-flight push land;
  // a new request needs two free slots beyond that.
  assign occ_w = {1'b0, q_count} - (CW+1)'(pop_n)
               + (inflight_q ? (CW+1)'(2) : (CW+1)'(0));
  assign room  = occ_w <= (CW+1)'(FQ_DEPTH - 2);

  assign state_d  = room ? FETCH : HOLD;
  assign im_req   = rst & (state_d == FETCH) & ~redirect_valid;
  assign im_addr0 = fetch_pc_q;
  assign im_addr1 = fetch_pc_q + PC_W'(1);

  assign push_n = (inflight_q && !squash_q && !redirect_valid)
                ? 2'd2 : 2'd0;
  assign q_push0 = '{ir: im_rdata0, pc: req_pc_q};
  assign q_push1 = '{ir: im_rdata1, pc: req_pc_q + PC_W'(1)};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (im_req)     fetch_pc_d = fetch_pc_q + PC_W'(2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      state_q    <= FETCH;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (im_req) req_pc_q <= fetch_pc_q;
      state_q    <= state_d;
      inflight_q <= im_req;
      squash_q   <= redirect_valid & inflight_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_ir_q <= NOP_INST;
      p1_ir_q <= NOP_INST;
      p0_pc_q <= '0;
      p1_pc_q <= '0;
      p0_v_q  <= 1'b0;
      p1_v_q  <= 1'b0;
    end else if (redirect_valid) begin
      p0_ir_q <= NOP_INST;
      p1_ir_q <= NOP_INST;
      p0_pc_q <= '0;
      p1_pc_q <= '0;
      p0_v_q  <= 1'b0;
      p1_v_q  <= 1'b0;
    end else if (adv) begin
      p0_ir_q <= (pop_n != 2'd0) ? q_head0.ir : NOP_INST;
      p0_pc_q <= (pop_n != 2'd0) ? q_head0.pc : '0;
      p0_v_q  <= (pop_n != 2'd0);
      p1_ir_q <= (pop_n == 2'd2) ? q_head1.ir : NOP_INST;
      p1_pc_q <= (pop_n == 2'd2) ? q_head1.pc : '0;
      p1_v_q  <= (pop_n == 2'd2);
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk    (clk),
    .rst    (rst),
    .push_n (push_n),
    .push0  (q_push0),
    .push1  (q_push1),
    .pop_n  (pop_n),
    .flush  (redirect_valid),
    .count  (q_count),
    .head0  (q_head0),
    .head1  (q_head1)
  );

  // HOLD means last cycle issued nothing, so nothing can be in flight.
  a_hold_idle: assert property (
    @(posedge clk) disable iff (!rst)
    (state_q == HOLD) |-> !inflight_q
  );

  assign p0_IR_out    = p0_ir_q;
  assign p1_IR_out    = p1_ir_q;
  assign p0_PC_out    = p0_pc_q;
  assign p1_PC_out    = p1_pc_q;
  assign p0_valid_out = p0_v_q;
  assign p1_valid_out = p1_v_q;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: memory model plus program-order scoreboard.
// Expected PCs are queued at reset/redirect and popped on each issue.
module tb_dual_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_next;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        im_req;
  logic [7:0]  im_addr0, im_addr1;
  logic [15:0] im_rdata0, im_rdata1;
  logic [15:0] p0_IR_out, p1_IR_out;
  logic [7:0]  p0_PC_out, p1_PC_out;
  logic        p0_valid_out, p1_valid_out;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_q [$];

  logic       adv_pend;
  logic       redir_pend;
  logic [7:0] prev_p0_pc, prev_p1_pc;
  logic       prev_p0_v, prev_p1_v;

  dual_fetch_unit #(
    .RESET_PC (8'hFE),
    .FQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_next     (fetch_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr0       (im_addr0),
    .im_addr1       (im_addr1),
    .im_rdata0      (im_rdata0),
    .im_rdata1      (im_rdata1),
    .p0_IR_out      (p0_IR_out),
    .p1_IR_out      (p1_IR_out),
    .p0_PC_out      (p0_PC_out),
    .p1_PC_out      (p1_PC_out),
    .p0_valid_out   (p0_valid_out),
    .p1_valid_out   (p1_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word k = 16'h1000 + k.
  always @(posedge clk) begin
    if (im_req) begin
      im_rdata0 <= 16'h1000 + {8'h00, im_addr0};
      im_rdata1 <= 16'h1000 + {8'h00, im_addr1};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic [7:0] start);
    logic [7:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(pc);
      pc = pc + 8'd1;
    end
  endtask

  task automatic sb_pop(input string tag,
                        input logic [7:0] pc,
                        input logic [15:0] ir);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, {24'h0, pc}, {24'h0, e});
      chk({tag, "_ir"}, {16'h0, ir}, {16'h0, 16'h1000 + {8'h00, e}});
    end
  endtask

  // Monitor: judges the edge just passed, then records what the
  // next edge will do from the inputs now stable.
  always @(negedge clk) begin
    if (!rst) begin
      adv_pend   = 1'b0;
      redir_pend = 1'b0;
    end else if (redir_pend) begin
      chk("redir_p0v", {31'h0, p0_valid_out}, 32'd0);
      chk("redir_p1v", {31'h0, p1_valid_out}, 32'd0);
      chk("redir_p0ir", {16'h0, p0_IR_out}, 32'h0);
    end else if (adv_pend) begin
      if (p0_valid_out) sb_pop("p0", p0_PC_out, p0_IR_out);
      if (p1_valid_out) begin
        chk("order_p0v", {31'h0, p0_valid_out}, 32'd1);
        sb_pop("p1", p1_PC_out, p1_IR_out);
      end
      if (!p1_valid_out)
        chk("nop_p1ir", {16'h0, p1_IR_out}, 32'h0);
    end else begin
      chk("hold_p0v", {31'h0, p0_valid_out}, {31'h0, prev_p0_v});
      chk("hold_p0pc", {24'h0, p0_PC_out}, {24'h0, prev_p0_pc});
      chk("hold_p1v", {31'h0, p1_valid_out}, {31'h0, prev_p1_v});
      chk("hold_p1pc", {24'h0, p1_PC_out}, {24'h0, prev_p1_pc});
    end
    prev_p0_v  = p0_valid_out;
    prev_p1_v  = p1_valid_out;
    prev_p0_pc = p0_PC_out;
    prev_p1_pc = p1_PC_out;
    if (rst) begin
      adv_pend   = fetch_next | ~p0_valid_out;
      redir_pend = redirect_valid;
    end
  end

  task automatic do_redirect(input logic [7:0] tgt, input logic fn);
    logic [7:0] t1;
    t1 = tgt + 8'd1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    fetch_next     = fn;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    fetch_next     = 1'b1;
    refill(tgt);
    #1;
    chk("rd_req", {31'h0, im_req}, 32'd1);
    chk("rd_addr0", {24'h0, im_addr0}, {24'h0, tgt});
    chk("rd_addr1", {24'h0, im_addr1}, {24'h0, t1});
    chk("rd_inv1", {31'h0, p0_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("rd_inv2", {31'h0, p0_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("rd_inv3", {31'h0, p0_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("rd_val", {31'h0, p0_valid_out}, 32'd1);
    chk("rd_pc", {24'h0, p0_PC_out}, {24'h0, tgt});
  endtask

  initial begin
    rst            = 1'b0;
    fetch_next     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    refill(8'hFE);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, im_req}, 32'd0);
    chk("rst_p0v", {31'h0, p0_valid_out}, 32'd0);
    chk("rst_p1v", {31'h0, p1_valid_out}, 32'd0);
    chk("rst_p0ir", {16'h0, p0_IR_out}, 32'h0);
    chk("rst_p1pc", {24'h0, p1_PC_out}, 32'h0);
    rst = 1'b1;
    #1;
    chk("first_req", {31'h0, im_req}, 32'd1);
    chk("first_a0", {24'h0, im_addr0}, 32'hFE);
    chk("first_a1", {24'h0, im_addr1}, 32'hFF);
    @(posedge clk); #1;
    chk("lat_e1", {31'h0, p0_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e2", {31'h0, p0_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e3", {31'h0, p0_valid_out}, 32'd1);
    chk("lat_pc", {24'h0, p0_PC_out}, 32'hFE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("steady", {31'h0, p0_valid_out & p1_valid_out}, 32'd1);
    end

    fetch_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) chk("stall_req", {31'h0, im_req}, 32'd0);
    end
    fetch_next = 1'b1;
    repeat (6) @(posedge clk);

    do_redirect(8'h40, 1'b0);
    repeat (4) @(posedge clk);
    do_redirect(8'h80, 1'b1);
    repeat (4) @(posedge clk);
    do_redirect(8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    do_redirect(8'h05, 1'b0);
    #1;
    fetch_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fetch_next = 1'b1;
    @(posedge clk); #1;
    fetch_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fetch_next = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
